// File: rtl/comp_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states and
// bit positions of the {gt,eq,lt} result bundle.
package comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned FLAG_W  = 3;
  localparam int unsigned FLAG_GT = 2;
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_LT = 0;

endpackage

// File: rtl/comp_2bit.sv
// Combinational 2-bit unsigned comparator slice.
module comp_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       s1,
  output logic       s2,
  output logic       s3
);

  assign s1 = (a > b);
  assign s2 = (a == b);
  assign s3 = (a < b);

endmodule

// File: rtl/comp_serial_ctrl.sv
// Serial WIDTH-bit magnitude comparator: walks 2-bit slices MSB first through
// one comp_2bit and stops at the first unequal slice.
module comp_serial_ctrl
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  output logic                      busy,
  output logic                      done,
  output logic                      gt,
  output logic                      eq,
  output logic                      lt,
  output logic [$clog2(WIDTH/2):0]  slices
);

  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned CNT_W  = $clog2(NSLICE) + 1;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state, state_d;
  logic [WIDTH-1:0]   a_r, a_d, b_r, b_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [CNT_W-1:0]   cnt, cnt_d, slices_d;
  logic [FLAG_W-1:0]  flags, flags_d;
  logic               busy_d, done_d;
  logic [1:0]         a_sl, b_sl;
  logic               s1, s2, s3;

  // Current slice, selected by idx from the latched operands
  assign a_sl = 2'(a_r >> {idx, 1'b0});
  assign b_sl = 2'(b_r >> {idx, 1'b0});

  comp_2bit u_comp (
    .a  (a_sl),
    .b  (b_sl),
    .s1 (s1),
    .s2 (s2),
    .s3 (s3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      idx    <= '0;
      cnt    <= '0;
      flags  <= '0;
      slices <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      a_r    <= a_d;
      b_r    <= b_d;
      idx    <= idx_d;
      cnt    <= cnt_d;
      flags  <= flags_d;
      slices <= slices_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    a_d      = a_r;
    b_d      = b_r;
    idx_d    = idx;
    cnt_d    = cnt;
    flags_d  = flags;
    slices_d = slices;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(NSLICE - 1);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt + CNT_W'(1);
        if (!s2) begin
          flags_d          = FLAG_W'(0);
          flags_d[FLAG_GT] = s1;
          flags_d[FLAG_LT] = s3;
          slices_d         = cnt + CNT_W'(1);
          state_d          = ST_DONE;
        end else if (idx == '0) begin
          flags_d          = FLAG_W'(0);
          flags_d[FLAG_EQ] = 1'b1;
          slices_d         = CNT_W'(NSLICE);
          state_d          = ST_DONE;
        end else begin
          idx_d = idx - IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Status flags are registered from the next state so they line up with it
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign gt = flags[FLAG_GT];
  assign eq = flags[FLAG_EQ];
  assign lt = flags[FLAG_LT];

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Directed bench for comp_serial_ctrl (WIDTH=8): expected results are queued at
// acceptance and checked by a monitor when done pulses.
module tb_comp_serial_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, gt, eq, lt;
  logic [2:0]       slices;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c0;

  typedef struct {
    logic gt;
    logic eq;
    logic lt;
    int   slices;
    int   c0;
    int   lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  comp_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .gt     (gt),
    .eq     (eq),
    .lt     (lt),
    .slices (slices)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic g, input logic e, input logic l,
                          input int s, input int c, input int lat);
    exp_t x;
    x.gt = g; x.eq = e; x.lt = l; x.slices = s; x.c0 = c; x.lat = lat;
    sb.push_back(x);
  endtask

  // Latency counts the accepting edge through the edge that raises done
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("gt", 32'(gt), 32'(mon_e.gt));
        chk("eq", 32'(eq), 32'(mon_e.eq));
        chk("lt", 32'(lt), 32'(mon_e.lt));
        chk("slices", 32'(slices), 32'(mon_e.slices));
        chk("latency", 32'(cyc - mon_e.c0 + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_cmp(input logic [7:0] av, input logic [7:0] bv,
                        input logic g, input logic e, input logic l, input int s);
    int nb;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(g, e, l, s, cyc, s + 1);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nb++;
      else break;
    end
    chk("busy_cycles", 32'(nb), 32'(s + 1));
    chk("drained", 32'(sb.size()), 32'd0);
    chk("held_slices", 32'(slices), 32'(s));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gt", 32'(gt), 32'd0);
    chk("rst_eq", 32'(eq), 32'd0);
    chk("rst_lt", 32'(lt), 32'd0);
    chk("rst_slices", 32'(slices), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_cmp(8'hA5, 8'h25, 1'b1, 1'b0, 1'b0, 1);
    do_cmp(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 4);
    do_cmp(8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 4);

    // Operands and start change while busy; latched copies decide the result
    @(negedge clk);
    a = 8'h80; b = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    push_exp(1'b1, 1'b0, 1'b0, 1, c0, 2);
    push_exp(1'b0, 1'b0, 1'b1, 1, c0 + 3, 2);
    @(negedge clk);
    a = 8'h00; b = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_gap_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("reaccept_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle(20);

    // Reset in the second RUN cycle aborts the compare
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_gt", 32'(gt), 32'd0);
    chk("mid_rst_eq", 32'(eq), 32'd0);
    chk("mid_rst_lt", 32'(lt), 32'd0);
    chk("mid_rst_slices", 32'(slices), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 32'd0);
    end
    do_cmp(8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 4);

    // Back-to-back with start held: acceptance every k+2 = 3 cycles
    @(negedge clk);
    a = 8'h40; b = 8'h80; start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    push_exp(1'b0, 1'b0, 1'b1, 1, c0, 2);
    push_exp(1'b0, 1'b0, 1'b1, 1, c0 + 3, 2);
    push_exp(1'b0, 1'b0, 1'b1, 1, c0 + 6, 2);
    repeat (6) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
